// File: rtl/alu_issue_buffer.sv
// Two-entry skid buffer feeding alu_module operands and opcode from registers.
// Optional handshake counter on issue_cnt when ISSUE_CNT_EN is defined.
module alu_issue_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_aluc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  aluc
`ifdef ISSUE_CNT_EN
    ,
    output logic [15:0] issue_cnt
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_aluc;
    logic [DATA_W-1:0]   r_skid_a;
    logic [DATA_W-1:0]   r_skid_b;
    logic [OP_W-1:0]     r_skid_aluc;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_in_hs   = in_valid & r_in_ready;
    assign w_out_hs  = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign aluc      = r_aluc;

    // Next state and data-move selects; flush wins and suppresses all loads
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_hs) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_hs) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_out_hs) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_hs) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Main register only changes on a load, so ALU inputs stay quiet when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_aluc      <= '0;
            r_skid_a    <= '0;
            r_skid_b    <= '0;
            r_skid_aluc <= '0;
        end else begin
            if (w_load_main_in) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_aluc <= in_aluc;
            end else if (w_load_main_skid) begin
                r_a    <= r_skid_a;
                r_b    <= r_skid_b;
                r_aluc <= r_skid_aluc;
            end
            if (w_load_skid) begin
                r_skid_a    <= in_a;
                r_skid_b    <= in_b;
                r_skid_aluc <= in_aluc;
            end
        end
    end

`ifdef ISSUE_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] r_issue_cnt;

    // Counts every output handshake, flush or not; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
        end else if (w_out_hs) begin
            r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Scoreboard bench for alu_issue_buffer; define ISSUE_CNT_EN to also exercise issue_cnt.
module tb_alu_issue_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_aluc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
`ifdef ISSUE_CNT_EN
    logic [15:0] issue_cnt;
    logic [15:0] exp_cnt = 16'd0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    int          n_before;
    logic [67:0] sb[$];
    logic [67:0] sb_front;

    always #5 clk = ~clk;

    alu_issue_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_aluc  (in_aluc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .b        (b),
        .aluc     (aluc)
`ifdef ISSUE_CNT_EN
        ,
        .issue_cnt(issue_cnt)
`endif
    );

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor at negedge: handshakes seen here complete on the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 68'(1), 68'(0));
                    end else begin
                        sb_front = sb.pop_front();
                        check("data_order", {a, b, aluc}, sb_front);
                    end
                    n_out++;
                end
                if (in_valid && in_ready) sb.push_back({in_a, in_b, in_aluc});
            end
`ifdef ISSUE_CNT_EN
            if (out_valid && out_ready) exp_cnt = exp_cnt + 16'd1;
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_aluc   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_out_valid", 68'(out_valid), 68'(0));
        check("rst_in_ready", 68'(in_ready), 68'(1));
        check("rst_a", 68'(a), 68'(0));
        check("rst_b", 68'(b), 68'(0));
        check("rst_aluc", 68'(aluc), 68'(0));
`ifdef ISSUE_CNT_EN
        check("rst_cnt", 68'(issue_cnt), 68'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single op, one-cycle latency
        in_valid  = 1'b1;
        in_a      = 32'h7FFFFFFF;
        in_b      = 32'h7FFF0000;
        in_aluc   = 4'b1011;
        out_ready = 1'b1;
        check("lat_in_ready_pre", 68'(in_ready), 68'(1));
        step();
        check("lat_out_valid", 68'(out_valid), 68'(1));
        check("lat_a", 68'(a), 68'(32'h7FFFFFFF));
        check("lat_b", 68'(b), 68'(32'h7FFF0000));
        check("lat_aluc", 68'(aluc), 68'(4'b1011));
        check("lat_in_ready", 68'(in_ready), 68'(1));
        in_valid = 1'b0;
        step();
        check("lat_drained", 68'(out_valid), 68'(0));

        // Backpressure: two accepted, third held, then ordered release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        in_aluc   = 4'b0100;
        step();
        check("bp_ready_one", 68'(in_ready), 68'(1));
        in_a    = $urandom;
        in_b    = $urandom;
        in_aluc = 4'b0101;
        step();
        check("bp_ready_two", 68'(in_ready), 68'(0));
        check("bp_head", 68'(aluc), 68'(4'b0100));
        in_a    = $urandom;
        in_b    = $urandom;
        in_aluc = 4'b0110;
        step();
        check("bp_still_full", 68'(in_ready), 68'(0));
        check("bp_hold", 68'(aluc), 68'(4'b0100));
        out_ready = 1'b1;
        step();
        check("bp_rel1", 68'(aluc), 68'(4'b0101));
        check("bp_rel1_ready", 68'(in_ready), 68'(1));
        step();
        check("bp_rel2", 68'(aluc), 68'(4'b0110));
        in_valid = 1'b0;
        step();
        check("bp_empty", 68'(out_valid), 68'(0));
        check("bp_idle_hold", 68'(aluc), 68'(4'b0110));

        // Ten-op stream with no bubbles
        n_before  = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            in_aluc  = 4'(i);
            step();
            check("stream_valid", 68'(out_valid), 68'(1));
            check("stream_ready", 68'(in_ready), 68'(1));
        end
        in_valid = 1'b0;
        step();
        step();
        check("stream_count", 68'(n_out - n_before), 68'(10));

        // Flush while full, with a simultaneous offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_aluc   = 4'h3;
        step();
        in_aluc = 4'h4;
        step();
        check("flush_pre_full", 68'(in_ready), 68'(0));
        flush   = 1'b1;
        in_aluc = 4'hF;
        in_a    = 32'hDEADBEEF;
        step();
        check("flush_out_valid", 68'(out_valid), 68'(0));
        check("flush_in_ready", 68'(in_ready), 68'(1));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("flush_stays_empty", 68'(out_valid), 68'(0));

        // Asynchronous reset pulse between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h1234_5678;
        step();
        step();
        check("arst_pre_full", 68'(in_ready), 68'(0));
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        sb.delete();
`ifdef ISSUE_CNT_EN
        exp_cnt = 16'd0;
`endif
        #1;
        check("arst_out_valid", 68'(out_valid), 68'(0));
        check("arst_a", 68'(a), 68'(0));
        check("arst_in_ready", 68'(in_ready), 68'(1));
        #1;
        rst = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'hCAFE_0001;
        in_b      = 32'h0000_0009;
        in_aluc   = 4'h9;
        out_ready = 1'b1;
        step();
        check("arst_first_aluc", 68'(aluc), 68'(4'h9));
        check("arst_first_a", 68'(a), 68'(32'hCAFE_0001));
        in_valid = 1'b0;
        step();

`ifdef ISSUE_CNT_EN
        check("cnt_one", 68'(issue_cnt), 68'(1));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_a    = $urandom;
            in_b    = $urandom;
            in_aluc = 4'($urandom);
            step();
            if (exp_cnt == 16'hFFFF) break;
        end
        check("cnt_max", 68'(issue_cnt), 68'(16'hFFFF));
        step();
        check("cnt_wrap", 68'(issue_cnt), 68'(16'h0000));
        in_valid = 1'b0;
`endif

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("sb_drained", 68'(sb.size()), 68'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_buffer.md
ALU_ISSUE_BUFFER -- requirements
Module: alu_issue_buffer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, upstream decoder offers an operation.
REQ-004 SHALL have port in_ready, output, 1, buffer accepts the offered operation this cycle.
REQ-005 SHALL have port in_a, input, 32, first operand.
REQ-006 SHALL have port in_b, input, 32, second operand.
REQ-007 SHALL have port in_aluc, input, 4, ALU operation code, passed through unmodified.
REQ-008 SHALL have port flush, input, 1, synchronous discard of all buffered operations.
REQ-009 SHALL have port out_valid, output, 1, an operation is presented to alu_module.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the presented operation.
REQ-011 SHALL have ports a, b (output, 32) and aluc (output, 4), driving alu_module inputs of the same names directly from registers.
REQ-012 SHALL have port issue_cnt, output, 16, count of completed output handshakes (present only with ISSUE_CNT_EN).

Function
REQ-013 SHALL implement a two-entry skid buffer: main register (drives a/b/aluc) plus skid register; states EMPTY, ONE, TWO.
REQ-014 SHALL assert in_ready iff state != TWO; in_ready SHALL depend only on registered state (no combinational path from out_ready).
REQ-015 SHALL assert out_valid iff state != EMPTY.
REQ-016 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-017 EMPTY: input handshake -> load main, go ONE; otherwise stay.
REQ-018 ONE: input only -> load skid, go TWO; output only -> go EMPTY; both -> load main from input, stay ONE; neither -> stay.
REQ-019 TWO: output handshake -> move skid into main, go ONE; otherwise hold.
REQ-020 Latency SHALL be 1 cycle: data accepted at edge N appears on a/b/aluc with out_valid after edge N when buffer was EMPTY.
REQ-021 Ordering SHALL be strict FIFO; no operation dropped, duplicated or reordered.
REQ-022 a/b/aluc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 flush=1 SHALL force state EMPTY at the next edge, overriding any simultaneous input or output handshake; data registers need not clear.
REQ-024 When state is EMPTY, a/b/aluc SHALL keep their last values (no toggling of ALU inputs on idle).

Reset
REQ-025 rst=1 SHALL immediately force state EMPTY, out_valid=0, in_ready=1, a=b=0, aluc=0, issue_cnt=0, independent of clk.
REQ-026 Reset asserted mid-transfer SHALL discard both entries; first accepted operation after release SHALL be the first presented.

Configuration
REQ-027 Macro ISSUE_CNT_EN defined: issue_cnt port present, increments by 1 on each output handshake, wraps 16'hFFFF -> 16'h0000, unaffected by flush.
REQ-028 Macro ISSUE_CNT_EN undefined: issue_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-029 Reset then in_valid=1, a=32'h7FFFFFFF, b=32'h7FFF0000, aluc=4'b1011, out_ready=1 -> next cycle out_valid=1, a/b/aluc equal those values, in_ready=1 throughout.
REQ-030 out_ready=0, push three ops (aluc 0100, 0101, 0110) -> first two accepted, in_ready=0 after second; third held; release out_ready -> outputs 0100, 0101, 0110 in order, one per cycle.
REQ-031 Streaming with out_ready=1 and in_valid=1 for 10 cycles -> 10 ops delivered back-to-back, state stays ONE, no bubble.
REQ-032 State TWO, flush=1 with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, flushed and offered ops never appear.
REQ-033 rst pulsed between clock edges while TWO -> out_valid=0 and a=0 before next edge.
REQ-034 ISSUE_CNT_EN: preload via 65535 handshakes then one more -> issue_cnt 16'hFFFF then 16'h0000.
